stack_reverser: RTL and testbench
=================================

# stack_reverser

Packet-reversal front end for the `stack` LIFO block. It accepts a packet as a valid/ready byte stream terminated by `s_last`, and pushes each beat into an external stack instance through its push/pop port set. It then pops the stack empty and emits the beats in reverse order on a valid/ready output stream, flagging the final beat with `m_last`. It is the initiator side of the stack interface: it drives `push`, `pop` and `data_in`, and consumes `data_out`, `full` and `empty`.

## Interface
- `DATA_WIDTH`, default 8: beat width; must equal the attached stack's `data_width`.
- `MAX_LEN`, default 200: maximum beats stored per packet; must not exceed the usable stack capacity.
- `CNT_W`, default 8: beat counter width; must satisfy 2**CNT_W > MAX_LEN.
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `s_valid`, input, 1: upstream beat valid.
- `s_ready`, output, 1: upstream beat accepted when high together with `s_valid`.
- `s_data`, input, DATA_WIDTH: upstream beat.
- `s_last`, input, 1: final beat of the upstream packet.
- `m_valid`, output, 1: downstream beat valid.
- `m_ready`, input, 1: downstream accepts.
- `m_data`, output, DATA_WIDTH: reversed beat.
- `m_last`, output, 1: final reversed beat.
- `err`, output, 1: one-cycle pulse when an overflowed packet finishes draining.
- `stk_push`, output, 1: drives the stack's `push`.
- `stk_pop`, output, 1: drives the stack's `pop`.
- `stk_din`, output, DATA_WIDTH: drives the stack's `data_in`.
- `stk_dout`, input, DATA_WIDTH: the stack's registered `data_out`.
- `stk_full`, input, 1: the stack's `full`.
- `stk_empty`, input, 1: the stack's `empty`; used for checking only.

## Operation
- FSM states: FILL, POP, WAIT, OUT.
- **FILL**
  - `s_ready` = 1.
  - On each accepted beat:
    - If not dropping, `count` < MAX_LEN and `stk_full` = 0: `stk_push` = 1, `stk_din` = `s_data`, `count` increments.
    - Otherwise: set `drop`; the beat is discarded.
  - An accepted beat with `s_last` moves the FSM to POP, or back to FILL (clearing `drop`) when `count` = 0 after that beat.
- **POP**
  - `stk_pop` = 1 for exactly one cycle, `count` decrements, go to WAIT.
- **WAIT**
  - Capture `stk_dout` into the `m_data` register.
  - `m_last` = (`count` == 0).
  - Go to OUT.
- **OUT**
  - `m_valid` = 1; `m_data`/`m_last` held stable until `m_ready`.
  - On handshake: if `m_last`, go to FILL, pulse `err` if `drop` was set, then clear `drop`; otherwise go to POP.
- `stk_push` and `stk_pop` are never high in the same cycle. `stk_pop` is issued only when `count` > 0.
- `count` is CNT_W bits unsigned and never wraps; it is bounded by MAX_LEN.

## Timing
- Reset values:
  - State FILL; `count`, `drop` = 0.
  - `m_valid`, `m_last`, `err`, `stk_push`, `stk_pop` = 0; `m_data` = 0.
  - `s_ready` = 0 while `rst` is high, and 1 on the first cycle after it is released.
- `s_ready`, `stk_push`, `stk_pop` and `stk_din` are combinational from state and inputs. `m_*` and `err` are registered.
- Fill throughput: 1 beat/cycle.
- Drain: 3 cycles/beat minimum (POP, WAIT, OUT) with `m_ready` held high.
- First `m_valid` appears 3 cycles after the edge that accepts the `s_last` beat.
- Stack timing relied on: push takes effect on the edge where `push & !full`; popped data is valid on `data_out` in the cycle after the pop edge.
- `s_ready` = 0 in POP/WAIT/OUT; upstream back-pressure lasts the whole drain.
- Reset mid-packet or mid-drain returns to FILL immediately. The external stack must share `rst`, so its pointer clears on the same edge.
- `m_ready` may be held low indefinitely in OUT; outputs stay stable and no pop is issued.

## Structure
- A shared package `stack_pkg` holds:
  - the FSM state typedef (FILL/POP/WAIT/OUT);
  - the default DATA_WIDTH;
  - a `STACK_SIZE`-derived capacity constant, used to default and check MAX_LEN.
- Single module with no sub-modules. The top-level integration instantiates `stack` alongside `stack_reverser` and wires the `stk_*` ports.

## Test plan
- Basic reversal: push 4 beats 0x11, 0x22, 0x33, 0x44 (`s_last` on 0x44), `m_ready` held 1 → out 0x44, 0x33, 0x22, 0x11; `m_last` only on 0x11; `err` stays 0.
- Single-beat packet: 0xA5 with `s_last` → one out beat 0xA5 with `m_last` = 1, 3 cycles after acceptance; `s_ready` returns to 1 after the handshake.
- Downstream back-pressure: 3-beat packet, `m_ready` low for 10 cycles at each beat → each beat held stable, `stk_pop` pulses exactly 3 times total, order reversed.
- Overflow: MAX_LEN = 4, send 6 beats 1..6 → out 4, 3, 2, 1; `m_last` on 1; `err` pulses for one cycle on the final handshake; beats 5 and 6 are discarded.
- Reset mid-drain: assert `rst` during OUT of the second beat → next cycle `m_valid` = 0, state FILL, `s_ready` = 1; the next packet 0x01, 0x02 returns 0x02, 0x01 with no stale data.
- Back-to-back packets: packet A (0x10, 0x20) followed immediately by packet B (0x30) → out 0x20, 0x10(last), 0x30(last); upstream stalls during A's drain.

Source files
------------

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared types and sizing constants for the stack and its
//                packet-reversal front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int STACK_SIZE     = 200;
  // Every stack entry is usable, so a packet may fill the whole stack.
  localparam int STACK_CAP      = STACK_SIZE;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic bit max_len_ok(input int max_len, input int cnt_w);
    return (max_len >= 1) && (max_len <= STACK_CAP) &&
           ((cnt_w >= 31) || ((1 << cnt_w) > max_len));
  endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_reverser.sv
`default_nettype none
// ============================================================================
//  Module      : stack_reverser
//  Description : Pushes a valid/ready packet into an external LIFO, then pops
//                it back out so the beats leave in reverse order.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_reverser
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LEN    = STACK_CAP,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_din,
  input  logic [DATA_WIDTH-1:0] stk_dout,
  input  logic                  stk_full,
  input  logic                  stk_empty
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  if (!max_len_ok(MAX_LEN, CNT_W)) begin : g_bad_params
    $error("stack_reverser: MAX_LEN exceeds stack capacity or CNT_W too narrow");
  end

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic                  drop_q,    drop_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q,  m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
  logic                  err_q,     err_d;

  logic w_accept;
  logic w_can_push;

  assign w_accept   = s_valid & s_ready;
  assign w_can_push = !drop_q && (count_q < MAX_CNT) && !stk_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      count_q   <= '0;
      drop_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    drop_d    = drop_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    err_d     = 1'b0;
    case (state_q)
      FILL: begin
        if (w_accept) begin
          if (w_can_push) count_d = count_q + CNT_W'(1);
          else            drop_d  = 1'b1;
          // A packet that stored nothing has nothing to drain.
          if (s_last) begin
            if (count_d == '0) begin
              state_d = FILL;
              drop_d  = 1'b0;
            end else begin
              state_d = POP;
            end
          end
        end
      end
      POP: begin
        if (count_q != '0) count_d = count_q - CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        m_data_d  = stk_dout;
        m_last_d  = (count_q == '0);
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            state_d = FILL;
            err_d   = drop_q;
            drop_d  = 1'b0;
          end else begin
            state_d = POP;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s_ready  = (state_q == FILL) && !rst;
    stk_push = s_valid && s_ready && w_can_push;
    stk_pop  = (state_q == POP) && (count_q != '0) && !stk_empty;
    stk_din  = s_data;
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule : stack_reverser
`default_nettype wire

// File: tb/tb_stack_reverser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_reverser
//  Description : Directed bench for stack_reverser with a behavioural stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_reverser;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          err;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic          stk_full;
  logic          stk_empty;

  int n_pass  = 0;
  int n_total = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  stack_reverser #(.DATA_WIDTH(DW), .MAX_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  // Behavioural 16-deep stack with registered data_out.
  logic [DW-1:0] stk_mem [0:15];
  logic [4:0]    stk_ptr;
  logic [DW-1:0] stk_dout_q;

  assign stk_full  = (stk_ptr == 5'd16);
  assign stk_empty = (stk_ptr == 5'd0);
  assign stk_dout  = stk_dout_q;

  always @(posedge clk) begin
    if (rst) begin
      stk_ptr    <= '0;
      stk_dout_q <= '0;
    end else if (stk_push && !stk_full) begin
      stk_mem[stk_ptr[3:0]] <= stk_din;
      stk_ptr <= stk_ptr + 5'd1;
    end else if (stk_pop && !stk_empty) begin
      stk_dout_q <= stk_mem[stk_ptr[3:0] - 4'd1];
      stk_ptr    <= stk_ptr - 5'd1;
    end
  end

  always @(posedge clk) begin
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop)  pop_cnt  <= pop_cnt + 1;
    if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic drive_beat(input logic [DW-1:0] d, input logic l, output bit ok);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    ok      = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (s_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Returns on the falling edge after the handshake edge.
  task automatic recv_beat(output logic [DW-1:0] d, output logic l, output bit ok);
    m_ready = 1'b1;
    d = '0;
    l = 1'b0;
    wait_valid(ok);
    if (ok) begin
      d = m_data;
      l = m_last;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    s_data  = 8'hEE;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (s_ready !== 1'b0) $display("FAIL reset_s_ready_low got=%b want=0", s_ready);
    else n_pass++;
    n_total++;
    if (stk_push !== 1'b0) $display("FAIL reset_no_push got=%b want=0", stk_push);
    else n_pass++;
    s_valid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    n_total++;
    if (s_ready !== 1'b1) $display("FAIL reset_s_ready_after got=%b want=1", s_ready);
    else n_pass++;
    n_total++;
    if ({m_valid, m_last, err, stk_pop, m_data} !== {4'b0000, 8'h00})
      $display("FAIL reset_outputs got=%b%b%b%b/%h want=0000/00", m_valid, m_last, err, stk_pop, m_data);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [DW-1:0] din [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [DW-1:0] d;
    logic l;
    bit ok;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(din[i], (i == 3), ok);
      n_total++;
      if (!ok) $display("FAIL basic_send beat=%0d got=timeout want=accepted", i);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      recv_beat(d, l, ok);
      n_total++;
      if (!ok || d !== exp[i] || l !== (i == 3) || err !== 1'b0)
        $display("FAIL basic_out beat=%0d got=%h last=%b err=%b ok=%b want=%h last=%b err=0",
                 i, d, l, err, ok, exp[i], (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_single();
    bit ok;
    m_ready = 1'b1;
    drive_beat(8'hA5, 1'b1, ok);
    n_total++;
    if (!ok || m_valid !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL single_cycle1 got=ok%b valid%b ready%b want=ok1 valid0 ready0", ok, m_valid, s_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (m_valid !== 1'b0) $display("FAIL single_cycle2 got=%b want=0", m_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_last !== 1'b1)
      $display("FAIL single_cycle3 got=v%b %h l%b want=v1 a5 l1", m_valid, m_data, m_last);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0)
      $display("FAIL single_after got=v%b r%b e%b want=v0 r1 e0", m_valid, s_ready, err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] din [3] = '{8'h5A, 8'h6B, 8'h7C};
    logic [DW-1:0] exp [3] = '{8'h7C, 8'h6B, 8'h5A};
    logic [DW-1:0] d;
    logic l;
    bit ok;
    bit stable;
    int pop_base;
    int pop_hold;
    m_ready  = 1'b0;
    pop_base = pop_cnt;
    for (int i = 0; i < 3; i++) drive_beat(din[i], (i == 2), ok);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      d = m_data;
      l = m_last;
      n_total++;
      if (!ok || d !== exp[k] || l !== (k == 2))
        $display("FAIL bp_data beat=%0d got=%h last=%b ok=%b want=%h last=%b", k, d, l, ok, exp[k], (k == 2));
      else n_pass++;
      stable   = 1'b1;
      pop_hold = pop_cnt;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (m_valid !== 1'b1 || m_data !== d || m_last !== l) stable = 1'b0;
      end
      n_total++;
      if (!stable || pop_cnt != pop_hold)
        $display("FAIL bp_hold beat=%0d got=stable%b pops%0d want=stable1 pops0", k, stable, pop_cnt - pop_hold);
      else n_pass++;
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
    end
    n_total++;
    if (pop_cnt - pop_base != 3) $display("FAIL bp_pop_count got=%0d want=3", pop_cnt - pop_base);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d;
    logic l;
    bit ok;
    int push_base;
    m_ready   = 1'b1;
    push_base = push_cnt;
    for (int i = 1; i <= 6; i++) drive_beat(DW'(i), (i == 6), ok);
    n_total++;
    if (push_cnt - push_base != 4) $display("FAIL ovf_pushes got=%0d want=4", push_cnt - push_base);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      recv_beat(d, l, ok);
      n_total++;
      if (!ok || d !== DW'(4 - k) || l !== (k == 3) || err !== (k == 3))
        $display("FAIL ovf_out beat=%0d got=%h last=%b err=%b ok=%b want=%h last=%b err=%b",
                 k, d, l, err, ok, DW'(4 - k), (k == 3), (k == 3));
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (err !== 1'b0 || stk_empty !== 1'b1)
      $display("FAIL ovf_err_pulse got=err%b empty%b want=err0 empty1", err, stk_empty);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    logic [DW-1:0] d;
    logic l;
    bit ok;
    m_ready = 1'b1;
    drive_beat(8'hC1, 1'b0, ok);
    drive_beat(8'hC2, 1'b0, ok);
    drive_beat(8'hC3, 1'b1, ok);
    recv_beat(d, l, ok);
    n_total++;
    if (!ok || d !== 8'hC3) $display("FAIL rstmid_first got=%h ok=%b want=c3", d, ok);
    else n_pass++;
    m_ready = 1'b0;
    wait_valid(ok);
    n_total++;
    if (!ok || m_data !== 8'hC2) $display("FAIL rstmid_second got=%h ok=%b want=c2", m_data, ok);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || stk_empty !== 1'b1)
      $display("FAIL rstmid_state got=v%b r%b empty%b want=v0 r1 empty1", m_valid, s_ready, stk_empty);
    else n_pass++;
    m_ready = 1'b1;
    drive_beat(8'h01, 1'b0, ok);
    drive_beat(8'h02, 1'b1, ok);
    recv_beat(d, l, ok);
    n_total++;
    if (!ok || d !== 8'h02 || l !== 1'b0) $display("FAIL rstmid_next0 got=%h last=%b want=02 last=0", d, l);
    else n_pass++;
    recv_beat(d, l, ok);
    n_total++;
    if (!ok || d !== 8'h01 || l !== 1'b1) $display("FAIL rstmid_next1 got=%h last=%b want=01 last=1", d, l);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [3] = '{8'h20, 8'h10, 8'h30};
    logic          expl [3] = '{1'b0, 1'b1, 1'b1};
    fork
      begin
        bit ok_s;
        drive_beat(8'h10, 1'b0, ok_s);
        drive_beat(8'h20, 1'b1, ok_s);
        drive_beat(8'h30, 1'b1, ok_s);
      end
      begin
        logic [DW-1:0] d;
        logic l;
        bit ok_r;
        for (int k = 0; k < 3; k++) begin
          recv_beat(d, l, ok_r);
          n_total++;
          if (!ok_r || d !== exp[k] || l !== expl[k])
            $display("FAIL b2b_out beat=%0d got=%h last=%b ok=%b want=%h last=%b", k, d, l, ok_r, exp[k], expl[k]);
          else n_pass++;
          if (k == 0) begin
            n_total++;
            if (s_valid !== 1'b1 || s_ready !== 1'b0)
              $display("FAIL b2b_stall got=valid%b ready%b want=valid1 ready0", s_valid, s_ready);
            else n_pass++;
          end
        end
      end
    join
  endtask

  task automatic test_exclusive();
    n_total++;
    if (both_cnt != 0) $display("FAIL push_pop_overlap got=%0d want=0", both_cnt);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_back_to_back();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_stack_reverser
`default_nettype wire
